// File: rtl/reg_cmd_bridge.sv
// Byte-stream command decoder: 'W' addr data[NB] / 'R' addr frames in, single-cycle
// register strobes out, ACK/NAK or read word bytes back to the transmitter.
module reg_cmd_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, READ, WAIT_RD, SEND, ACK} state_t;

  state_t                state_q;
  logic                  op_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, shreg_q;
  logic                  wen_q, ren_q, tx_valid_q, err_q;
  logic [7:0]            tx_data_q;
  logic [1:0]            err_code_q;
  logic [CW-1:0]         cnt_q;
  logic [LW-1:0]         lat_q;
  logic [TW-1:0]         to_q;

  logic [TW-1:0]         to_d;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic                  to_hit, in_frame, in_xact;

  assign to_d     = to_q + 1'b1;
  assign to_hit   = (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign shreg_d  = shreg_q << 8;
  assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign in_xact  = !in_frame && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shreg_q    <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      to_q       <= '0;
    end else begin
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      err_q <= 1'b0;
      to_q  <= (in_frame && !rx_valid) ? to_d : '0;
      case (state_q)
        IDLE: if (rx_valid) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            op_wr_q <= (rx_data == 8'h57);
            state_q <= GET_ADDR;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= 2'd1;
            tx_data_q  <= 8'h15;
            tx_valid_q <= 1'b1;
            state_q    <= ACK;
          end
        end
        GET_ADDR: if (rx_valid) begin
          addr_q <= ADDR_WIDTH'(rx_data);
          if (op_wr_q) begin
            cnt_q   <= '0;
            state_q <= GET_DATA;
          end else begin
            ren_q   <= 1'b1;
            state_q <= READ;
          end
        end else if (to_hit) begin
          err_q      <= 1'b1;
          err_code_q <= 2'd2;
          state_q    <= IDLE;
        end
        GET_DATA: if (rx_valid) begin
          wdata_q <= DATA_WIDTH'({wdata_q, rx_data});
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NB - 1)) begin
            wen_q   <= 1'b1;
            state_q <= WRITE;
          end
        end else if (to_hit) begin
          err_q      <= 1'b1;
          err_code_q <= 2'd2;
          state_q    <= IDLE;
        end
        WRITE: begin
          tx_data_q  <= 8'h06;
          tx_valid_q <= 1'b1;
          state_q    <= ACK;
        end
        READ: begin
          lat_q   <= '0;
          state_q <= WAIT_RD;
        end
        // rdata is sampled on the READ_LAT-th cycle after the ren cycle
        WAIT_RD: if (lat_q == LW'(READ_LAT - 1)) begin
          shreg_q    <= rdata;
          tx_data_q  <= rdata[DATA_WIDTH-1 -: 8];
          tx_valid_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= SEND;
        end else begin
          lat_q <= lat_q + 1'b1;
        end
        SEND: if (tx_ready) begin
          if (cnt_q == CW'(NB - 1)) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            shreg_q   <= shreg_d;
            tx_data_q <= shreg_d[DATA_WIDTH-1 -: 8];
            cnt_q     <= cnt_q + 1'b1;
          end
        end
        ACK: if (tx_ready) begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Bytes arriving mid-transaction are dropped; the transaction itself carries on
      if (rx_valid && in_xact) begin
        err_q      <= 1'b1;
        err_code_q <= 2'd3;
      end
    end
  end

  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign wen      = wen_q;
  assign ren      = ren_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Directed bench for reg_cmd_bridge: frame table plus stall/overrun/timeout/reset sequences.
module tb_reg_cmd_bridge;
  logic        clk = 1'b0, reset = 1'b1;
  logic [7:0]  rx_data = '0, tx_data;
  logic        rx_valid = 1'b0, tx_valid, tx_ready = 1'b1;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata = '0;
  logic        wen, ren, busy, err;
  logic [1:0]  err_code;

  reg_cmd_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LAT(1), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addr(addr), .wdata(wdata), .wen(wen), .ren(ren), .rdata(rdata),
    .busy(busy), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  // Register block stand-in: one-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (wen) mem[addr] <= wdata;
    if (ren) rdata <= mem[addr];
  end

  int n_wen = 0, n_ren = 0, n_both = 0, n_err = 0;
  logic [7:0]  w_addr, r_addr;
  logic [31:0] w_data;
  logic [7:0]  txq [$];
  always @(negedge clk) begin
    if (wen) begin n_wen++; w_addr = addr; w_data = wdata; end
    if (ren) begin n_ren++; r_addr = addr; end
    if (wen && ren) n_both++;
    if (err) n_err++;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  int nvec = 0, nfail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    tick();
  endtask

  task automatic wait_txv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic chk_tx4(input string nm, input int base, input logic [31:0] w);
    chk({nm, "_n"}, txq.size() - base, 4);
    for (int j = 0; j < 4 && base + j < txq.size(); j++)
      chk($sformatf("%s_b%0d", nm, j), txq[base + j], w[31 - 8*j -: 8]);
  endtask

  typedef struct {
    int          nb;
    logic [47:0] by;
    bit          wr, rd;
    logic [7:0]  a;
    logic [31:0] d;
    int          ntx;
    logic [31:0] tx;
    logic [1:0]  code;
    int          nerr;
  } vec_t;

  function automatic vec_t mk(int nb, logic [47:0] by, bit wr, bit rd, logic [7:0] a,
                              logic [31:0] d, int ntx, logic [31:0] tx, logic [1:0] code, int nerr);
    vec_t v;
    v.nb = nb; v.by = by; v.wr = wr; v.rd = rd; v.a = a; v.d = d;
    v.ntx = ntx; v.tx = tx; v.code = code; v.nerr = nerr;
    return v;
  endfunction

  vec_t v [10];
  int   s_wen, s_ren, s_err, s_tx, k;
  bit   ok;

  initial begin
    v[0] = mk(6, 48'h57_00_000000FF, 1, 0, 8'h00, 32'h000000FF, 1, 32'h06, 2'd0, 0);
    v[1] = mk(6, 48'h57_04_A5A5A5A5, 1, 0, 8'h04, 32'hA5A5A5A5, 1, 32'h06, 2'd0, 0);
    v[2] = mk(6, 48'h57_08_12345678, 1, 0, 8'h08, 32'h12345678, 1, 32'h06, 2'd0, 0);
    v[3] = mk(6, 48'h57_0C_11223344, 1, 0, 8'h0C, 32'h11223344, 1, 32'h06, 2'd0, 0);
    v[4] = mk(6, 48'h57_10_CAFEF00D, 1, 0, 8'h10, 32'hCAFEF00D, 1, 32'h06, 2'd0, 0);
    v[5] = mk(2, 48'h52_04_00000000, 0, 1, 8'h04, 32'h0, 4, 32'hA5A5A5A5, 2'd0, 0);
    v[6] = mk(2, 48'h52_08_00000000, 0, 1, 8'h08, 32'h0, 4, 32'h12345678, 2'd0, 0);
    v[7] = mk(2, 48'h52_00_00000000, 0, 1, 8'h00, 32'h0, 4, 32'h000000FF, 2'd0, 0);
    v[8] = mk(2, 48'h52_0C_00000000, 0, 1, 8'h0C, 32'h0, 4, 32'h11223344, 2'd0, 0);
    v[9] = mk(1, 48'h41_00_00000000, 0, 0, 8'h00, 32'h0, 1, 32'h15, 2'd1, 1);

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_code", err_code, 0);
    chk("rst_strb", {wen, ren, err}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      s_wen = n_wen; s_ren = n_ren; s_err = n_err; s_tx = txq.size();
      for (int b = 0; b < v[i].nb; b++) send(v[i].by[47 - 8*b -: 8]);
      wait_idle(ok);
      chk($sformatf("v%0d_idle", i), ok, 1);
      chk($sformatf("v%0d_wen", i), n_wen - s_wen, v[i].wr);
      chk($sformatf("v%0d_ren", i), n_ren - s_ren, v[i].rd);
      if (v[i].wr) begin
        chk($sformatf("v%0d_waddr", i), w_addr, v[i].a);
        chk($sformatf("v%0d_wdata", i), w_data, v[i].d);
      end
      if (v[i].rd) chk($sformatf("v%0d_raddr", i), r_addr, v[i].a);
      chk($sformatf("v%0d_ntx", i), txq.size() - s_tx, v[i].ntx);
      for (int j = 0; j < v[i].ntx && s_tx + j < txq.size(); j++)
        chk($sformatf("v%0d_tx%0d", i, j), txq[s_tx + j], v[i].tx[8*(v[i].ntx-1-j) +: 8]);
      chk($sformatf("v%0d_nerr", i), n_err - s_err, v[i].nerr);
      chk($sformatf("v%0d_code", i), err_code, v[i].code);
    end

    // Transmitter stall before the second byte must hold tx_data/tx_valid
    tx_ready = 1'b0; s_tx = txq.size();
    send(8'h52); send(8'h0C);
    wait_txv(ok);
    chk("stall_txv0", ok, 1);
    chk("stall_b0", tx_data, 8'h11);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_v%0d", c), tx_valid, 1);
      chk($sformatf("stall_d%0d", c), tx_data, 8'h22);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle(ok);
    chk("stall_idle", ok, 1);
    chk_tx4("stall", s_tx, 32'h11223344);

    // Overrun during SEND: byte dropped, read still completes
    tx_ready = 1'b0; s_tx = txq.size(); s_wen = n_wen;
    send(8'h52); send(8'h0C);
    wait_txv(ok);
    chk("ovr_txv", ok, 1);
    s_err = n_err;
    send(8'h33);
    chk("ovr_err", err, 1);
    chk("ovr_code", err_code, 3);
    tx_ready = 1'b1;
    wait_idle(ok);
    chk("ovr_idle", ok, 1);
    chk_tx4("ovr", s_tx, 32'h11223344);
    chk("ovr_nerr", n_err - s_err, 1);
    chk("ovr_wen", n_wen - s_wen, 0);

    // Timeout after a partial write frame, then a normal read
    s_wen = n_wen;
    send(8'h57); send(8'h10); send(8'hAA);
    for (k = 1; k <= 40; k++) begin
      tick();
      if (err) break;
    end
    chk("to_cycle", k, 20);
    chk("to_code", err_code, 2);
    tick();
    chk("to_busy", busy, 0);
    chk("to_wen", n_wen - s_wen, 0);
    s_tx = txq.size();
    send(8'h52); send(8'h10);
    wait_idle(ok);
    chk("to_rd_idle", ok, 1);
    chk_tx4("to_rd", s_tx, 32'hCAFEF00D);

    // Reset in the middle of GET_DATA
    s_wen = n_wen;
    send(8'h57); send(8'h20); send(8'h11); send(8'h22);
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_tx", {tx_valid, tx_data}, 0);
    chk("mid_addr", addr, 0);
    chk("mid_wdata", wdata, 0);
    chk("mid_code", err_code, 0);
    chk("mid_strb", {wen, ren, err}, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("mid_wen", n_wen - s_wen, 0);
    chk("both_strobes", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
